// File: rtl/jogo_pkg.sv
// Shared constants for the memory-game blocks: button width, debounce length
// and the state encoding of the jogada detector.
package jogo_pkg;

  localparam int N_BOTOES_PADRAO        = 4;
  localparam int DEBOUNCE_CICLOS_PADRAO = 5;
  localparam int CNT_W                  = 8;

  typedef enum logic [1:0] {
    ESPERA      = 2'd0,
    FILTRO      = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTURA     = 2'd3
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; clears on synchronous
// active-low reset.
module sincronizador_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] ff1_q;
  logic [WIDTH-1:0] ff2_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff2_in(ff1_q);
    end
  end

  function automatic logic [WIDTH-1:0] ff2_in(input logic [WIDTH-1:0] v);
    return v;
  endfunction

  assign q_o = ff2_q;

endmodule

// File: rtl/detector_jogada.sv
// Debounces the board buttons and turns each physical press into one
// registered jogada code plus a single-cycle valid/invalid strobe.
//
// state       | meaning
// ESPERA      | idle, all buttons released, waiting for a press
// FILTRO      | counting stable cycles of a candidate pattern
// PRESSIONADO | press accepted (or ignored), waiting for release
// SOLTURA     | counting stable released cycles before re-arming
module detector_jogada
  import jogo_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_valida,
  output logic                jogada_invalida,
  output logic                db_tem_jogada,
  output logic [3:0]          db_estado
);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic [N_BOTOES-1:0] s;

  estado_t             estado_q,   estado_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [N_BOTOES-1:0] padrao_q,   padrao_d;
  logic [N_BOTOES-1:0] jogada_q,   jogada_d;
  logic                valida_q,   valida_d;
  logic                invalida_q, invalida_d;
  logic                padrao_one_hot;

  sincronizador_2ff #(
    .WIDTH (N_BOTOES)
  ) u_sinc (
    .clock (clock),
    .reset (reset),
    .d_i   (botoes),
    .q_o   (s)
  );

  // Clearing the lowest set bit leaves zero only for a single-bit pattern.
  assign padrao_one_hot = (padrao_q != '0) &&
                          ((padrao_q & (padrao_q - N_BOTOES'(1))) == '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q   <= SOLTURA;
      cnt_q      <= '0;
      padrao_q   <= '0;
      jogada_q   <= '0;
      valida_q   <= 1'b0;
      invalida_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      padrao_q   <= padrao_d;
      jogada_q   <= jogada_d;
      valida_q   <= valida_d;
      invalida_q <= invalida_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    padrao_d   = padrao_q;
    jogada_d   = jogada_q;
    valida_d   = 1'b0;
    invalida_d = 1'b0;

    case (estado_q)
      ESPERA: begin
        if (s != '0) begin
          cnt_d = '0;
          if (habilita) begin
            padrao_d = s;
            estado_d = FILTRO;
          end else begin
            // Press arrived while disabled: swallow it and demand a release.
            estado_d = SOLTURA;
          end
        end
      end

      FILTRO: begin
        if (s != padrao_q) begin
          estado_d = ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_FIM) begin
            estado_d = PRESSIONADO;
            if (habilita) begin
              jogada_d   = padrao_q;
              valida_d   = padrao_one_hot;
              invalida_d = !padrao_one_hot;
            end
          end
        end
      end

      PRESSIONADO: begin
        if (s == '0) begin
          cnt_d    = '0;
          estado_d = SOLTURA;
        end
      end

      SOLTURA: begin
        if (s != '0) begin
          estado_d = PRESSIONADO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_FIM) begin
            estado_d = ESPERA;
          end
        end
      end

      default: begin
        estado_d = SOLTURA;
        cnt_d    = '0;
      end
    endcase
  end

  assign jogada          = jogada_q;
  assign jogada_valida   = valida_q;
  assign jogada_invalida = invalida_q;
  assign db_tem_jogada   = |s;
  assign db_estado       = {2'b00, estado_q};

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada: reset, valid/invalid presses, bounce,
// glitch, disabled press and reset during filtering.
module tb_detector_jogada;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       habilita;
  logic [3:0] jogada;
  logic       jogada_valida;
  logic       jogada_invalida;
  logic       db_tem_jogada;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;

  // Pulse-cycle counters, written only by the monitor below.
  int n_val   = 0;
  int n_inv   = 0;
  int n_ambos = 0;
  int base_val;
  int base_inv;

  detector_jogada dut (
    .clock           (clock),
    .reset           (reset),
    .botoes          (botoes),
    .habilita        (habilita),
    .jogada          (jogada),
    .jogada_valida   (jogada_valida),
    .jogada_invalida (jogada_invalida),
    .db_tem_jogada   (db_tem_jogada),
    .db_estado       (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (jogada_valida)                     n_val++;
    if (jogada_invalida)                   n_inv++;
    if (jogada_valida && jogada_invalida)  n_ambos++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic marca;
    base_val = n_val;
    base_inv = n_inv;
  endtask

  initial begin
    reset    = 1'b0;
    botoes   = 4'b0000;
    habilita = 1'b0;

    // Reset
    tick(2);
    check("rst_jogada",   32'(jogada), 32'h0);
    check("rst_valida",   32'(jogada_valida), 32'h0);
    check("rst_invalida", 32'(jogada_invalida), 32'h0);
    check("rst_estado",   32'(db_estado), 32'h3);
    check("rst_tem",      32'(db_tem_jogada), 32'h0);
    reset = 1'b1;
    tick(4);
    check("rst_soltura_4", 32'(db_estado), 32'h3);
    tick(1);
    check("rst_espera_5",  32'(db_estado), 32'h0);

    // Valid press 0001: pulse in the cycle after edge 8
    habilita = 1'b1;
    botoes   = 4'b0001;
    marca();
    tick(2);
    check("val_tem", 32'(db_tem_jogada), 32'h1);
    tick(1);
    check("val_filtro", 32'(db_estado), 32'h1);
    tick(4);
    check("val_cedo", 32'(jogada_valida), 32'h0);
    tick(1);
    check("val_pulso",   32'(jogada_valida), 32'h1);
    check("val_jogada",  32'(jogada), 32'h1);
    check("val_pressed", 32'(db_estado), 32'h2);
    tick(1);
    check("val_fim_pulso", 32'(jogada_valida), 32'h0);
    tick(1);
    botoes = 4'b0000;
    tick(10);
    check("val_n_val",   32'(n_val - base_val), 32'h1);
    check("val_n_inv",   32'(n_inv - base_inv), 32'h0);
    check("val_hold",    32'(jogada), 32'h1);
    check("val_espera",  32'(db_estado), 32'h0);

    // Invalid press 1010
    botoes = 4'b1010;
    marca();
    tick(8);
    check("inv_pulso",  32'(jogada_invalida), 32'h1);
    check("inv_jogada", 32'(jogada), 32'ha);
    tick(2);
    botoes = 4'b0000;
    tick(10);
    check("inv_n_val", 32'(n_val - base_val), 32'h0);
    check("inv_n_inv", 32'(n_inv - base_inv), 32'h1);

    // Bounce 0100/0000 every 2 cycles, then stable 0100
    marca();
    for (int k = 0; k < 2; k++) begin
      botoes = 4'b0100; tick(2);
      botoes = 4'b0000; tick(2);
    end
    check("bnc_sem_pulso", 32'(n_val - base_val), 32'h0);
    botoes = 4'b0100;
    tick(10);
    botoes = 4'b0000;
    tick(10);
    check("bnc_n_val",  32'(n_val - base_val), 32'h1);
    check("bnc_n_inv",  32'(n_inv - base_inv), 32'h0);
    check("bnc_jogada", 32'(jogada), 32'h4);

    // 3-cycle glitch 0010
    marca();
    botoes = 4'b0010;
    tick(3);
    botoes = 4'b0000;
    tick(10);
    check("gli_n_val",  32'(n_val - base_val), 32'h0);
    check("gli_n_inv",  32'(n_inv - base_inv), 32'h0);
    check("gli_jogada", 32'(jogada), 32'h4);

    // Press while disabled, then an enabled press
    marca();
    habilita = 1'b0;
    botoes   = 4'b0001;
    tick(10);
    botoes = 4'b0000;
    tick(10);
    check("dis_n_val",  32'(n_val - base_val), 32'h0);
    check("dis_jogada", 32'(jogada), 32'h4);
    check("dis_espera", 32'(db_estado), 32'h0);
    habilita = 1'b1;
    botoes   = 4'b0010;
    tick(10);
    botoes = 4'b0000;
    tick(10);
    check("dis_apos_n_val",  32'(n_val - base_val), 32'h1);
    check("dis_apos_jogada", 32'(jogada), 32'h2);

    // Reset during FILTRO with 1000 held
    marca();
    botoes = 4'b1000;
    tick(4);
    check("rmid_filtro", 32'(db_estado), 32'h1);
    reset = 1'b0;
    tick(1);
    check("rmid_estado", 32'(db_estado), 32'h3);
    check("rmid_jogada", 32'(jogada), 32'h0);
    reset = 1'b1;
    tick(15);
    check("rmid_n_val",   32'(n_val - base_val), 32'h0);
    check("rmid_pressed", 32'(db_estado), 32'h2);
    botoes = 4'b0000;
    tick(10);
    check("rmid_solto_n_val", 32'(n_val - base_val), 32'h0);
    check("rmid_solto_jog",   32'(jogada), 32'h0);
    botoes = 4'b1000;
    tick(10);
    botoes = 4'b0000;
    tick(10);
    check("rmid_nova_n_val",  32'(n_val - base_val), 32'h1);
    check("rmid_nova_jogada", 32'(jogada), 32'h8);

    check("nunca_ambos", 32'(n_ambos), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
